// File: rtl/fnv1a_32.sv
// Registered 32-bit FNV-1a hash: four bytes of `in` per clock, digest on `out`.
// Define FNV1A_ACCUM_EN to chain the digest across words (seed = current out).
module fnv1a_32 #(
  parameter logic [31:0] OFFSET_BASIS = 32'h811C9DC5,
  parameter logic [31:0] FNV_PRIME    = 32'h01000193
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in,
  output logic [31:0] out
);

  logic [31:0] out_q;
  logic [31:0] out_d;
  logic [31:0] seed;
  logic [31:0] h0;
  logic [31:0] h1;
  logic [31:0] h2;

  // Standard prime maps to a shift-add; any other prime falls back to a multiplier.
  function automatic logic [31:0] fnv_step(input logic [31:0] h, input logic [7:0] b);
    logic [31:0] x;
    x = h ^ {24'b0, b};
    if (FNV_PRIME == 32'h01000193)
      return (x << 24) + (x << 8) + (x << 7) + (x << 4) + (x << 1) + x;
    else
      return x * FNV_PRIME;
  endfunction

  always_comb begin
`ifdef FNV1A_ACCUM_EN
    seed = out_q;
`else
    seed = OFFSET_BASIS;
`endif
    h0    = fnv_step(seed, in[7:0]);
    h1    = fnv_step(h0,   in[15:8]);
    h2    = fnv_step(h1,   in[23:16]);
    out_d = fnv_step(h2,   in[31:24]);
  end

  always_ff @(posedge clk) begin
    if (reset)
      out_q <= OFFSET_BASIS;
    else
      out_q <= out_d;
  end

  assign out = out_q;

endmodule

// File: tb/tb_fnv1a_32.sv
// Self-checking bench for fnv1a_32; honours FNV1A_ACCUM_EN the same way the design does.
module tb_fnv1a_32;

  localparam logic [31:0] BASIS = 32'h811C9DC5;

  logic        clk;
  logic        reset;
  logic [31:0] in;
  logic [31:0] out;

  int          n_assert;
  int          n_fail;
  logic [31:0] model_seed;
  logic [31:0] last_exp;
  logic [31:0] out_one;
  logic [31:0] out_hundred;

  fnv1a_32 dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: byte-serial FNV-1a with full-width multiply, reduced mod 2^32.
  function automatic logic [31:0] ref_hash(input logic [31:0] seed, input logic [31:0] w);
    longint unsigned h;
    longint unsigned b;
    h = {32'b0, seed};
    for (int i = 0; i < 4; i++) begin
      b = ({32'b0, w} >> (8 * i)) & 64'd255;
      h = ((h ^ b) * 64'h0000_0000_0100_0193) % 64'h0000_0001_0000_0000;
    end
    return h[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_edge(input string tag, input logic [31:0] w);
    reset = 1'b1;
    in    = w;
    @(posedge clk);
    #1;
    check(tag, out, BASIS);
    model_seed = BASIS;
    reset = 1'b0;
  endtask

  task automatic step(input string tag, input logic [31:0] w);
    in = w;
    @(posedge clk);
    #1;
    last_exp = ref_hash(model_seed, w);
    check(tag, out, last_exp);
`ifdef FNV1A_ACCUM_EN
    model_seed = last_exp;
`endif
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    model_seed = BASIS;
    reset      = 1'b1;
    in         = 32'hDEADBEEF;

    reset_edge("reset_edge1", 32'hDEADBEEF);
    reset      = 1'b1;
    reset_edge("reset_edge2", 32'hDEADBEEF);

    // Registered, not combinational: out holds the basis until the next edge.
    in = 32'h0000_0000;
    #2;
    check("no_comb_path", out, BASIS);
    step("zero_word", 32'h0000_0000);

    step("word_01", 32'h0000_0001);
    out_one = out;
    step("word_0100", 32'h0000_0100);
    out_hundred = out;
    n_assert++;
    assert (out_one !== out_hundred) else begin
      n_fail++;
      $error("[TB] FAIL byte_order: observed %h expected value different from %h", out_hundred, out_one);
    end
    step("word_12345678", 32'h1234_5678);
    step("word_ffffffff", 32'hFFFF_FFFF);

    reset_edge("midstream_reset", 32'h1234_5678);
    step("resume_after_reset", 32'h1234_5678);

    reset_edge("chain_reset", 32'h0);
    step("abcd_first", 32'h6162_6364);
    check("abcd_first_is_stateless", out, ref_hash(BASIS, 32'h6162_6364));
    step("efgh_second", 32'h6566_6768);

    reset_edge("random_reset", 32'hFFFF_FFFF);
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] w;
      w = $urandom;
      step("random_word", w);
`ifndef FNV1A_ACCUM_EN
      n_assert++;
      assert (out !== w) else begin
        n_fail++;
        $error("[TB] FAIL out_differs_from_in: observed %h expected value different from %h", out, w);
      end
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
